// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one line-wide memory port between I-cache refill
// and D-cache refill/writeback. Define MEM_ARB_RR_EN for round-robin I/D arbitration.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128,
    parameter int OFF_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_req_i,
    input  logic [ADDR_W-1:0] icache_addr_i,
    output logic              icache_ready_o,
    output logic [LINE_W-1:0] icache_data_o,
    input  logic              dcache_rd_req_i,
    input  logic [ADDR_W-1:0] dcache_rd_addr_i,
    input  logic              dcache_wb_req_i,
    input  logic [ADDR_W-1:0] dcache_wb_addr_i,
    input  logic [LINE_W-1:0] dcache_wb_data_i,
    output logic              dcache_ready_o,
    output logic [LINE_W-1:0] dcache_data_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i
);
    typedef enum logic [2:0] {IDLE, G_IRD, G_DRD, G_DWB, DONE} state_t;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              iready_q, iready_d;
    logic              dready_q, dready_d;
    logic [LINE_W-1:0] idata_q, idata_d;
    logic [LINE_W-1:0] ddata_q, ddata_d;
    logic              pick_i;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

`ifdef MEM_ARB_RR_EN
    // 1 = D class was granted last, so I wins the next I/D tie
    logic last_d_q, last_d_d;
    assign pick_i = icache_req_i && (!(dcache_wb_req_i || dcache_rd_req_i) || last_d_q);
`else
    assign pick_i = icache_req_i && !(dcache_wb_req_i || dcache_rd_req_i);
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        iready_d    = 1'b0;
        dready_d    = 1'b0;
        idata_d     = idata_q;
        ddata_d     = ddata_q;
`ifdef MEM_ARB_RR_EN
        last_d_d    = last_d_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_i) begin
                    state_d     = G_IRD;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = line_addr(icache_addr_i);
                    mem_wdata_d = '0;
`ifdef MEM_ARB_RR_EN
                    last_d_d    = 1'b0;
`endif
                end else if (dcache_wb_req_i) begin
                    // dirty victim goes out before its replacement is fetched
                    state_d     = G_DWB;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = line_addr(dcache_wb_addr_i);
                    mem_wdata_d = dcache_wb_data_i;
`ifdef MEM_ARB_RR_EN
                    last_d_d    = 1'b1;
`endif
                end else if (dcache_rd_req_i) begin
                    state_d     = G_DRD;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = line_addr(dcache_rd_addr_i);
                    mem_wdata_d = '0;
`ifdef MEM_ARB_RR_EN
                    last_d_d    = 1'b1;
`endif
                end
            end
            G_IRD, G_DRD, G_DWB: begin
                if (mem_ready_i) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    iready_d  = (state_q == G_IRD);
                    dready_d  = (state_q != G_IRD);
                    if (state_q == G_IRD) idata_d = mem_rdata_i;
                    if (state_q == G_DRD) ddata_d = mem_rdata_i;
                end
            end
            // one dead cycle so the requester can drop req before re-arbitration
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            iready_q    <= 1'b0;
            dready_q    <= 1'b0;
            idata_q     <= '0;
            ddata_q     <= '0;
`ifdef MEM_ARB_RR_EN
            last_d_q    <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            iready_q    <= iready_d;
            dready_q    <= dready_d;
            idata_q     <= idata_d;
            ddata_q     <= ddata_d;
`ifdef MEM_ARB_RR_EN
            last_d_q    <= last_d_d;
`endif
        end
    end

    assign mem_req_o      = mem_req_q;
    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign icache_ready_o = iready_q;
    assign icache_data_o  = idata_q;
    assign dcache_ready_o = dready_q;
    assign dcache_data_o  = ddata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: latency-programmable memory model, in-order scoreboard of
// expected transfers, vector table plus eviction, contention, spurious-ready and reset cases.
module tb_mem_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic         icache_req_i, dcache_rd_req_i, dcache_wb_req_i;
    logic [31:0]  icache_addr_i, dcache_rd_addr_i, dcache_wb_addr_i;
    logic [127:0] dcache_wb_data_i;
    logic         icache_ready_o, dcache_ready_o, mem_req_o, mem_we_o;
    logic [127:0] icache_data_o, dcache_data_o, mem_wdata_o, mem_rdata_i;
    logic [31:0]  mem_addr_o;
    logic         mem_ready_i;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .icache_req_i(icache_req_i), .icache_addr_i(icache_addr_i),
        .icache_ready_o(icache_ready_o), .icache_data_o(icache_data_o),
        .dcache_rd_req_i(dcache_rd_req_i), .dcache_rd_addr_i(dcache_rd_addr_i),
        .dcache_wb_req_i(dcache_wb_req_i), .dcache_wb_addr_i(dcache_wb_addr_i),
        .dcache_wb_data_i(dcache_wb_data_i),
        .dcache_ready_o(dcache_ready_o), .dcache_data_o(dcache_data_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           port;   // 0 = I, 1 = D
        logic [31:0]  addr;
        logic         we;
        logic [127:0] wdata;
        logic [127:0] rdata;
        int           lat;
    } exp_t;

    typedef struct {
        int           kind;   // 0 = I read, 1 = D read, 2 = D writeback
        logic [31:0]  addr;
        logic [127:0] wdata;
        int           lat;
        logic [31:0]  exp_addr;
        logic         exp_we;
    } vec_t;

    exp_t         sb[$];
    exp_t         e;
    int           tests = 0, fails = 0;
    int           lat = 1, mcnt = 0, reqcnt = 0;
    logic         spur = 1'b0, hit;
    logic         mr_at_edge = 1'b0;
    logic [31:0]  g_addr;
    logic         g_we;
    logic [127:0] g_wdata;
    logic [127:0] exp_idata = '0, exp_ddata = '0;

    function automatic logic [127:0] line_of(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_0F0F, a + 32'h1234_5678};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // memory: ready pulse on the lat-th cycle of mem_req_o, garbage rdata otherwise
    initial begin
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            hit = 1'b0;
            if (!mem_req_o || rst || mem_ready_i) mcnt = 0;
            else begin
                mcnt++;
                if (mcnt >= lat) hit = 1'b1;
            end
            mem_ready_i = hit | spur;
            mem_rdata_i = hit ? line_of(mem_addr_o) : {4{32'hDEAD_BEEF}};
        end
    end

    always @(posedge clk) mr_at_edge <= mem_ready_i;

    // monitor: every ack pops one expected transfer
    initial begin
        forever begin
            @(negedge clk);
            if (rst) reqcnt = 0;
            else begin
                if (mem_req_o) begin
                    reqcnt++;
                    g_addr  = mem_addr_o;
                    g_we    = mem_we_o;
                    g_wdata = mem_wdata_o;
                end
                if (icache_ready_o || dcache_ready_o) begin
                    check("single_ready", 128'(icache_ready_o & dcache_ready_o), 128'(0));
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_ack: got i=%0b d=%0b expected no ack",
                                 icache_ready_o, dcache_ready_o);
                    end else begin
                        e = sb.pop_front();
                        check("ack_port", 128'(dcache_ready_o), 128'(e.port));
                        check("mem_addr", 128'(g_addr), 128'(e.addr));
                        check("mem_we", 128'(g_we), 128'(e.we));
                        if (e.we) check("mem_wdata", g_wdata, e.wdata);
                        else if (e.port == 0) check("icache_data", icache_data_o, e.rdata);
                        else check("dcache_data", dcache_data_o, e.rdata);
                        check("req_cycles", 128'(reqcnt), 128'(e.lat));
                        check("req_dropped", 128'(mem_req_o), 128'(0));
                        check("ack_latency", 128'(mr_at_edge), 128'(1));
                    end
                    reqcnt = 0;
                end
            end
        end
    end

    task automatic push_exp(input int kind, input logic [31:0] a, input logic [127:0] wd);
        exp_t x;
        x.port  = (kind == 0) ? 0 : 1;
        x.addr  = a;
        x.we    = (kind == 2);
        x.wdata = wd;
        x.rdata = (kind == 2) ? '0 : line_of(a);
        x.lat   = lat;
        sb.push_back(x);
        if (kind == 0) exp_idata = x.rdata;
        if (kind == 1) exp_ddata = x.rdata;
    endtask

    task automatic raise(input int kind, input logic [31:0] a, input logic [127:0] wd);
        case (kind)
            0: begin icache_req_i = 1'b1; icache_addr_i = a; end
            1: begin dcache_rd_req_i = 1'b1; dcache_rd_addr_i = a; end
            default: begin dcache_wb_req_i = 1'b1; dcache_wb_addr_i = a; dcache_wb_data_i = wd; end
        endcase
    endtask

    task automatic drop(input int kind);
        case (kind)
            0: icache_req_i = 1'b0;
            1: dcache_rd_req_i = 1'b0;
            default: dcache_wb_req_i = 1'b0;
        endcase
    endtask

    task automatic wait_ack(input int port, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (port == 0 ? icache_ready_o : dcache_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: got no ack on port %0d within 200 cycles expected one", port);
            sb.delete();
        end
    endtask

    task automatic agent(input int kind, input logic [31:0] base, input int n);
        bit ok;
        for (int k = 0; k < n; k++) begin
            raise(kind, base + 32'(k * 64), '0);
            wait_ack(kind == 0 ? 0 : 1, ok);
            if (!ok) break;
        end
        drop(kind);
    endtask

    vec_t vt[6];
    bit   ok;

    initial begin
        vt[0] = '{0, 32'h0000_0104, '0,                                    3, 32'h0000_0100, 1'b0};
        vt[1] = '{1, 32'h0001_23FF, '0,                                    1, 32'h0001_23F0, 1'b0};
        vt[2] = '{2, 32'h0000_2000, {16{8'hA5}},                           2, 32'h0000_2000, 1'b1};
        vt[3] = '{0, 32'hFFFF_FFFF, '0,                                    5, 32'hFFFF_FFF0, 1'b0};
        vt[4] = '{1, 32'h0000_0000, '0,                                    1, 32'h0000_0000, 1'b0};
        vt[5] = '{2, 32'h8000_000C, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 4, 32'h8000_0000, 1'b1};

        icache_req_i = 0; dcache_rd_req_i = 0; dcache_wb_req_i = 0;
        icache_addr_i = '0; dcache_rd_addr_i = '0; dcache_wb_addr_i = '0; dcache_wb_data_i = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mem_req", 128'(mem_req_o), 128'(0));
        check("rst_mem_we", 128'(mem_we_o), 128'(0));
        check("rst_mem_addr", 128'(mem_addr_o), 128'(0));
        check("rst_mem_wdata", mem_wdata_o, '0);
        check("rst_iready", 128'(icache_ready_o), 128'(0));
        check("rst_idata", icache_data_o, '0);
        check("rst_dready", 128'(dcache_ready_o), 128'(0));
        check("rst_ddata", dcache_data_o, '0);
        rst = 1'b0;
        @(negedge clk);

        // single I read: request seen in IDLE -> mem_req_o the next cycle
        lat = 3;
        push_exp(0, 32'h0000_0100, '0);
        raise(0, 32'h0000_0104, '0);
        @(negedge clk);
        check("grant_req", 128'(mem_req_o), 128'(1));
        check("grant_addr", 128'(mem_addr_o), 128'(32'h0000_0100));
        check("grant_we", 128'(mem_we_o), 128'(0));
        wait_ack(0, ok);
        drop(0);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            lat = vt[i].lat;
            push_exp(vt[i].kind, vt[i].exp_addr, vt[i].wdata);
            check("vec_we_model", 128'(vt[i].kind == 2), 128'(vt[i].exp_we));
            raise(vt[i].kind, vt[i].addr, vt[i].wdata);
            wait_ack(vt[i].kind == 0 ? 0 : 1, ok);
            drop(vt[i].kind);
            repeat (2) @(negedge clk);
        end

        // eviction pair: writeback first, then the refill
        lat = 2;
        push_exp(2, 32'h0000_2000, {16{8'hA5}});
        push_exp(1, 32'h0000_3000, '0);
        raise(2, 32'h0000_2000, {16{8'hA5}});
        raise(1, 32'h0000_3000, '0);
        wait_ack(1, ok);
        drop(2);
        if (ok) wait_ack(1, ok);
        drop(1);
        repeat (2) @(negedge clk);

        // I/D contention: I agent 2 transfers, D agent 4 transfers, raised together
        lat = 2;
`ifdef MEM_ARB_RR_EN
        push_exp(0, 32'h0000_6000, '0);
        push_exp(1, 32'h0000_5000, '0);
        push_exp(0, 32'h0000_6040, '0);
        push_exp(1, 32'h0000_5040, '0);
        push_exp(1, 32'h0000_5080, '0);
        push_exp(1, 32'h0000_50C0, '0);
`else
        push_exp(1, 32'h0000_5000, '0);
        push_exp(1, 32'h0000_5040, '0);
        push_exp(1, 32'h0000_5080, '0);
        push_exp(1, 32'h0000_50C0, '0);
        push_exp(0, 32'h0000_6000, '0);
        push_exp(0, 32'h0000_6040, '0);
`endif
        exp_idata = line_of(32'h0000_6040);
        exp_ddata = line_of(32'h0000_50C0);
        fork
            agent(0, 32'h0000_6000, 2);
            agent(1, 32'h0000_5000, 4);
        join
        repeat (3) @(negedge clk);
        check("contention_drained", 128'(sb.size()), 128'(0));

        // spurious mem_ready_i in IDLE
        spur = 1'b1;
        repeat (2) @(negedge clk);
        spur = 1'b0;
        repeat (3) @(negedge clk);
        check("spur_iready", 128'(icache_ready_o), 128'(0));
        check("spur_dready", 128'(dcache_ready_o), 128'(0));
        check("spur_idata", icache_data_o, exp_idata);
        check("spur_ddata", dcache_data_o, exp_ddata);
        check("spur_no_req", 128'(mem_req_o), 128'(0));

        // reset in the second cycle of G_DRD
        lat = 10;
        raise(1, 32'h0000_4000, '0);
        repeat (2) @(negedge clk);
        check("mid_req_high", 128'(mem_req_o), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_req", 128'(mem_req_o), 128'(0));
        check("mid_rst_addr", 128'(mem_addr_o), 128'(0));
        check("mid_rst_ddata", dcache_data_o, '0);
        check("mid_rst_idata", icache_data_o, '0);
        rst = 1'b0;
        drop(1);
        exp_idata = '0;
        exp_ddata = '0;
        repeat (15) @(negedge clk);
        check("mid_no_dready", 128'(dcache_ready_o), 128'(0));
        check("mid_idle", 128'(mem_req_o), 128'(0));

        // arbiter still usable after the abandoned transfer
        lat = 2;
        push_exp(0, 32'h0000_7770, '0);
        raise(0, 32'h0000_7778, '0);
        wait_ack(0, ok);
        drop(0);
        repeat (3) @(negedge clk);
        check("sb_drained", 128'(sb.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
